// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused; the FSM recovers from it to SA_IDLE.
  typedef enum logic [1:0] {
    SA_IDLE   = 2'd0,
    SA_SHIFT  = 2'd1,
    SA_FINISH = 2'd2
  } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, WIDTH shift cycles
// per addition, framed by a START/DONE handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_e        state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit, cout_bit;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (sum_bit),
    .Cout (cout_bit)
  );

  assign s_next = {sum_bit, s_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= SA_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      SA_IDLE:   if (START) state_nxt = SA_SHIFT;
      SA_SHIFT:  if (cnt == CNT_LAST) state_nxt = SA_FINISH;
      SA_FINISH: state_nxt = SA_IDLE;
      default:   state_nxt = SA_IDLE;
    endcase
  end

  // Operand capture, serial shifting and result registration.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        SA_IDLE: begin
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
            s_sr  <= '0;
          end
        end
        SA_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= cout_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            S    <= s_next;
            Cout <= cout_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == SA_SHIFT) || (state == SA_FINISH);
  assign DONE = (state == SA_FINISH);

endmodule
